// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder controller (optional BCD_SUB_EN adds subtract)
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
`ifdef BCD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, next_state;
    logic [W-1:0]    op_a, op_b;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            err_acc;
    logic            sub_q;
    logic            sub_in;
    logic            accept;
    logic            last;
    logic [3:0]      a_d, b_raw, b_d, digit;
    logic [4:0]      t;
    logic            carry_next;
    logic            dig_err;

`ifdef BCD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == IW'(DIGITS - 1));
    assign busy   = (state == ADD);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADD;
            ADD:     if (last)  next_state = DONE;
            DONE:    next_state = start ? ADD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shared digit stage; subtraction feeds the nines' complement of b.
    always_comb begin
        a_d        = op_a[{idx, 2'b00} +: 4];
        b_raw      = op_b[{idx, 2'b00} +: 4];
        b_d        = sub_q ? (4'd9 - b_raw) : b_raw;
        t          = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
        carry_next = (t > 5'd9);
        digit      = carry_next ? (t[3:0] + 4'd6) : t[3:0];
        dig_err    = (a_d > 4'd9) || (b_raw > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            err_acc <= 1'b0;
            sub_q   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b;
            sub_q   <= sub_in;
            carry   <= sub_in ? 1'b1 : cin;
            idx     <= '0;
            err_acc <= 1'b0;
        end else if (state == ADD) begin
            sum[{idx, 2'b00} +: 4] <= digit;
            carry   <= carry_next;
            err_acc <= err_acc | dig_err;
            if (last) begin
                cout <= carry_next;
                err  <= err_acc | dig_err;
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule
